instr_fetch_unit: RTL and testbench

- Fetch stage for the jacaranda-8 core.
- Maintains the PC and reads 8-bit instructions from instruction memory over a req/ack interface.
- Presents each instruction, split into its fields, to the main controller over a valid/ready handshake.
- Applies jmp/je redirects that the controller decodes for the instruction being consumed.

---
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the jacaranda-8 core.
// It fetches one instruction byte, holds it for decode, and then applies any redirect taken at the handshake.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr,
    output logic [3:0]        opcode,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jmp_en,
    input  logic              je_en,
    input  logic              flag,
    input  logic [ADDR_W-1:0] br_target,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              req_reg;
    logic              valid_reg;
    logic [7:0]        instr_reg;
    logic [ADDR_W-1:0] instr_pc_reg;
    logic [15:0]       count_reg;
    logic              take_branch;

    // jmp_en wins over je_en; the redirect inputs matter only on the handshake cycle.
    assign take_branch = jmp_en | (je_en & flag);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            instr_reg    <= 8'h00;
            instr_pc_reg <= '0;
            count_reg    <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= FETCH;
                    req_reg   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg    <= imem_rdata;
                        instr_pc_reg <= pc_reg;
                        pc_reg       <= pc_reg + ADDR_W'(1);
                        req_reg      <= 1'b0;
                        valid_reg    <= 1'b1;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        count_reg <= count_reg + 16'd1;
                        valid_reg <= 1'b0;
                        req_reg   <= 1'b1;
                        state_reg <= FETCH;
                        if (take_branch) begin
                            pc_reg <= br_target;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign instr_valid = valid_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign fetch_count = count_reg;

    assign opcode = instr_reg[7:4];
    assign rd     = instr_reg[3:2];
    assign rs     = instr_reg[1:0];
    assign imm    = instr_reg[3:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. It runs directed vectors, a reset-during-fetch sequence,
// and random transactions checked against a transaction-level PC and count model.
module tb_instr_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm;
    logic [7:0] instr_pc;
    logic       jmp_en = 1'b0;
    logic       je_en = 1'b0;
    logic       flag = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic [15:0] fetch_count;

    int compared   = 0;
    int mismatched = 0;
    int exp_count  = 0;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
        .instr_pc(instr_pc),
        .jmp_en(jmp_en), .je_en(je_en), .flag(flag), .br_target(br_target),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         ack_wait;
        int         ready_wait;
        logic       jmp;
        logic       je;
        logic       flg;
        logic [7:0] target;
        logic [7:0] next;
    } vec_t;

    vec_t tbl [13];
    logic [7:0] mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // This task performs one complete transaction: request, optional ack wait, hold, optional stall, handshake.
    task automatic do_fetch(input logic [7:0] exp_addr, input logic [7:0] data,
                            input int ack_wait, input int ready_wait,
                            input logic jmp, input logic je, input logic flg,
                            input logic [7:0] target, input logic [7:0] exp_next);
        int n;
        logic [7:0] d;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack = 1'b0;
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'(exp_addr));
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        d = data;
        chk("valid", 32'(instr_valid), 32'd1);
        chk("req_low", 32'(imem_req), 32'd0);
        chk("instr", 32'(instr), 32'(d));
        chk("opcode", 32'(opcode), 32'(d[7:4]));
        chk("rd", 32'(rd), 32'(d[3:2]));
        chk("rs", 32'(rs), 32'(d[1:0]));
        chk("imm", 32'(imm), 32'(d[3:0]));
        chk("instr_pc", 32'(instr_pc), 32'(exp_addr));
        for (int i = 0; i < ready_wait; i++) begin
            // A stray ack and random redirect inputs during the stall must be ignored.
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(1));
            imem_rdata  = 8'($urandom);
            jmp_en      = 1'($urandom_range(1));
            je_en       = 1'($urandom_range(1));
            flag        = 1'($urandom_range(1));
            br_target   = 8'($urandom);
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'(d));
            chk("stall_pc", 32'(instr_pc), 32'(exp_addr));
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_count", 32'(fetch_count), 32'(exp_count));
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jmp_en      = jmp;
        je_en       = je;
        flag        = flg;
        br_target   = target;
        tick();
        instr_ready = 1'b0;
        jmp_en      = 1'($urandom_range(1));
        je_en       = 1'($urandom_range(1));
        flag        = 1'($urandom_range(1));
        br_target   = 8'($urandom);
        exp_count   = (exp_count + 1) % 65536;
        chk("count", 32'(fetch_count), 32'(exp_count));
        chk("post_valid", 32'(instr_valid), 32'd0);
        chk("post_req", 32'(imem_req), 32'd1);
        chk("next_addr", 32'(imem_addr), 32'(exp_next));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pc_model;
        logic       j, e, f;
        logic [7:0] t, nx;
        int         aw, rw;

        tbl[0]  = '{8'h00, 8'h1D, 0, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
        tbl[1]  = '{8'h01, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02};
        tbl[2]  = '{8'h02, 8'h11, 3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03};
        tbl[3]  = '{8'h03, 8'h22, 1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04};
        tbl[4]  = '{8'h04, 8'hB2, 0, 0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h40};
        tbl[5]  = '{8'h40, 8'hB3, 0, 2, 1'b1, 1'b0, 1'b0, 8'h07, 8'h07};
        tbl[6]  = '{8'h07, 8'hC1, 0, 0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h08};
        tbl[7]  = '{8'h08, 8'hB0, 2, 0, 1'b1, 1'b0, 1'b0, 8'h07, 8'h07};
        tbl[8]  = '{8'h07, 8'hC1, 0, 1, 1'b0, 1'b1, 1'b1, 8'h20, 8'h20};
        tbl[9]  = '{8'h20, 8'hB1, 0, 0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF};
        tbl[10] = '{8'hFF, 8'h44, 0, 0, 1'b0, 1'b0, 1'b0, 8'h33, 8'h00};
        tbl[11] = '{8'h00, 8'h1D, 0, 0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h01};
        tbl[12] = '{8'h01, 8'hB2, 0, 0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02};

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        reset = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_fetch(tbl[i].addr, tbl[i].data, tbl[i].ack_wait, tbl[i].ready_wait,
                     tbl[i].jmp, tbl[i].je, tbl[i].flg, tbl[i].target, tbl[i].next);
        end

        // Reset arrives in the second wait cycle of a fetch at address 2, so the request is abandoned.
        chk("abandon_addr", 32'(imem_addr), 32'd2);
        imem_ack = 1'b0;
        tick();
        chk("abandon_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_count", 32'(fetch_count), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_instr", 32'(instr), 32'd0);
        tick();
        chk("refetch_req", 32'(imem_req), 32'd1);
        do_fetch(8'h00, 8'h5A, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);

        // The random phase uses a transaction-level model of the next PC after each consumed instruction.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        pc_model = 8'h01;
        for (int k = 0; k < 200; k++) begin
            aw = int'($urandom_range(3));
            rw = int'($urandom_range(3));
            j  = ($urandom_range(3) == 0);
            e  = ($urandom_range(2) == 0);
            f  = 1'($urandom_range(1));
            t  = 8'($urandom);
            if (j || (e && f)) nx = t;
            else               nx = 8'((int'(pc_model) + 1) % 256);
            do_fetch(pc_model, mem[pc_model], aw, rw, j, e, f, t, nx);
            pc_model = nx;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
